pwm_ctrl_seq: RTL and testbench
===============================

PWM_CTRL_SEQ -- requirements
Module: pwm_ctrl_seq

Interface
REQ-001 The block SHALL have these ports: clk  in  1  clock, all logic on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 cfg_valid  in  1  host configuration write request.
REQ-004 cfg_ready  out  1  block can accept a configuration write.
REQ-005 cfg_addr  in  3  shadow register select: 0 = period, 1 = compare1, 2 = compare2, 3 = functions[1:0], 4 = prescale[7:0].
REQ-006 cfg_wdata  in  16  write data; unused upper bits ignored.
REQ-007 start  in  1  single-cycle pulse, begin or resume generation.
REQ-008 stop  in  1  single-cycle pulse, finish current period then halt.
REQ-009 pwm_en, period[15:0], functions[1:0], compare1[15:0], compare2[15:0], count_val[15:0]  out  active settings and counter driven to the PWM generator.
REQ-010 period_end  out  1  one-cycle pulse on counter wrap.
REQ-011 busy  out  1  high in RUN or DRAIN.

Function
REQ-012 A write SHALL occur when cfg_valid && cfg_ready; it updates only the addressed shadow register and sets the dirty flag; unmapped addresses are accepted and discarded without setting dirty.
REQ-013 cfg_ready SHALL be 1 except in the single cycle in which shadow-to-active commit occurs.
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-015 IDLE: pwm_en = 0, count_val = 0, prescaler = 0; start -> copy all shadows to active, clear dirty, go to RUN next cycle.
REQ-016 RUN/DRAIN: pwm_en = 1; prescaler counts 0..prescale; a tick occurs in the cycle the prescaler equals prescale, and the prescaler then returns to 0; prescale = 0 gives a tick every cycle.
REQ-017 On a tick, count_val SHALL increment by 1, except when count_val >= period-1, when it wraps to 0 and period_end pulses in the same cycle as the wrap.
REQ-018 period = 0 SHALL be treated as period = 1: count_val stays 0 and period_end pulses on every tick.
REQ-019 On a wrap with dirty = 1, all shadows SHALL be copied to active in that cycle, dirty is cleared, and cfg_ready = 0 for that cycle; active values change only at wraps, never mid-period.
REQ-020 A write accepted in the cycle before a wrap SHALL be included in that commit.
REQ-021 stop in RUN -> DRAIN; stop in IDLE or DRAIN is ignored.
REQ-022 DRAIN: on wrap -> IDLE, with commit per REQ-019 before leaving.
REQ-023 start in DRAIN -> RUN, with no counter disturbance; start in RUN is ignored.
REQ-024 start and stop in the same cycle: stop wins.

Reset
REQ-025 On rst_n low, all outputs and state SHALL asynchronously go to: state IDLE, pwm_en 0, count_val 0, period_end 0, busy 0, cfg_ready 1, active and shadow registers 0, dirty 0, prescaler 0.
REQ-026 Reset asserted mid-operation SHALL abort immediately, discarding pending shadows.

Configuration
REQ-027 Macro PWM_CTRL_ONESHOT_EN defined: cfg_addr 5 bit0 SHALL be a shadow oneshot bit, committed like other shadows; when active oneshot = 1, RUN moves to DRAIN automatically at start, so exactly one period is generated before IDLE.
REQ-028 Macro PWM_CTRL_ONESHOT_EN undefined: address 5 SHALL be unmapped per REQ-012, and no oneshot logic is present.

Verification
REQ-029 Write period = 4, compare1 = 2, prescale = 0, then start -> pwm_en = 1 the next cycle; count_val 0,1,2,3,0...; period_end high when count_val 3->0.
REQ-030 In RUN at count_val = 1, write compare1 = 3 -> compare1 output stays 2 until the wrap, then becomes 3 in the same cycle as period_end, with cfg_ready = 0 in that cycle only.
REQ-031 prescale = 2, period = 3 -> count_val advances every 3rd cycle; period_end every 9 cycles.
REQ-032 stop at count_val = 1 (period = 4) -> busy stays 1 through 2,3; at wrap state = IDLE, pwm_en = 0, count_val = 0; start and stop in the same cycle in RUN -> DRAIN.
REQ-033 period = 0 -> count_val constant 0, period_end on every tick; rst_n low mid-RUN -> all outputs at reset values asynchronously.
REQ-034 With PWM_CTRL_ONESHOT_EN defined, oneshot = 1, period = 5 -> exactly one period_end, then IDLE.

Source files
------------

// File: rtl/pwm_ctrl_seq_if.sv
// pwm_ctrl_seq_if: host configuration write channel.
// Master drives the write; slave answers with cfg_ready.
interface pwm_ctrl_seq_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_ctrl_seq.sv
// pwm_ctrl_seq: shadowed PWM settings committed only at period wrap.
// Optional macro PWM_CTRL_ONESHOT_EN adds a one-period mode bit.
module pwm_ctrl_seq (
    input  logic          clk,
    input  logic          rst_n,
    pwm_ctrl_seq_if.slave cfg,
    input  logic          start,
    input  logic          stop,
    output logic          pwm_en,
    output logic [15:0]   period,
    output logic [1:0]    functions,
    output logic [15:0]   compare1,
    output logic [15:0]   compare2,
    output logic [15:0]   count_val,
    output logic          period_end,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state;
    logic [15:0] sh_period;
    logic [15:0] sh_cmp1;
    logic [15:0] sh_cmp2;
    logic [1:0]  sh_func;
    logic [7:0]  sh_pre;
    logic [7:0]  act_pre;
    logic [7:0]  prescaler;
    logic        dirty;

    logic [15:0] nx_period;
    logic [15:0] nx_cmp1;
    logic [15:0] nx_cmp2;
    logic [1:0]  nx_func;
    logic [7:0]  nx_pre;
    logic        nx_dirty;

    logic        tick;
    logic        wrap;
    logic        do_start;
    logic        do_commit;
    logic        drain_req;
    logic        shot_done;

`ifdef PWM_CTRL_ONESHOT_EN
    logic        sh_shot;
    logic        act_shot;
    logic        nx_shot;
`endif

    // Shadow image after this cycle's write, so a commit includes it
    always_comb begin
        nx_period = sh_period;
        nx_cmp1   = sh_cmp1;
        nx_cmp2   = sh_cmp2;
        nx_func   = sh_func;
        nx_pre    = sh_pre;
        nx_dirty  = dirty;
`ifdef PWM_CTRL_ONESHOT_EN
        nx_shot   = sh_shot;
`endif
        if (cfg.cfg_valid && cfg.cfg_ready) begin
            case (cfg.cfg_addr)
                3'd0: begin
                    nx_period = cfg.cfg_wdata;
                    nx_dirty  = 1'b1;
                end
                3'd1: begin
                    nx_cmp1  = cfg.cfg_wdata;
                    nx_dirty = 1'b1;
                end
                3'd2: begin
                    nx_cmp2  = cfg.cfg_wdata;
                    nx_dirty = 1'b1;
                end
                3'd3: begin
                    nx_func  = cfg.cfg_wdata[1:0];
                    nx_dirty = 1'b1;
                end
                3'd4: begin
                    nx_pre   = cfg.cfg_wdata[7:0];
                    nx_dirty = 1'b1;
                end
`ifdef PWM_CTRL_ONESHOT_EN
                3'd5: begin
                    nx_shot  = cfg.cfg_wdata[0];
                    nx_dirty = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign tick = (state != IDLE) && (prescaler == act_pre);
    // period 0 behaves as period 1: every tick wraps
    assign wrap = tick && ((period <= 16'd1) ||
                           (count_val >= period - 16'd1));
    assign do_start  = (state == IDLE) && start && !stop;
    assign do_commit = do_start || (wrap && nx_dirty);

`ifdef PWM_CTRL_ONESHOT_EN
    assign drain_req = stop || act_shot;
    assign shot_done = act_shot && wrap;
`else
    assign drain_req = stop;
    assign shot_done = 1'b0;
`endif

    // Shadow/active register file and commit handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_period     <= '0;
            sh_cmp1       <= '0;
            sh_cmp2       <= '0;
            sh_func       <= '0;
            sh_pre        <= '0;
            period        <= '0;
            compare1      <= '0;
            compare2      <= '0;
            functions     <= '0;
            act_pre       <= '0;
            dirty         <= 1'b0;
            cfg.cfg_ready <= 1'b1;
`ifdef PWM_CTRL_ONESHOT_EN
            sh_shot       <= 1'b0;
            act_shot      <= 1'b0;
`endif
        end else begin
            sh_period     <= nx_period;
            sh_cmp1       <= nx_cmp1;
            sh_cmp2       <= nx_cmp2;
            sh_func       <= nx_func;
            sh_pre        <= nx_pre;
            dirty         <= nx_dirty && !do_commit;
            cfg.cfg_ready <= !do_commit;
`ifdef PWM_CTRL_ONESHOT_EN
            sh_shot       <= nx_shot;
`endif
            if (do_commit) begin
                period    <= nx_period;
                compare1  <= nx_cmp1;
                compare2  <= nx_cmp2;
                functions <= nx_func;
                act_pre   <= nx_pre;
`ifdef PWM_CTRL_ONESHOT_EN
                act_shot  <= nx_shot;
`endif
            end
        end
    end

    // Run-control FSM with prescaler and period counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pwm_en     <= 1'b0;
            busy       <= 1'b0;
            count_val  <= '0;
            prescaler  <= '0;
            period_end <= 1'b0;
        end else begin
            period_end <= wrap;
            if (state == IDLE) begin
                count_val <= '0;
                prescaler <= '0;
            end else if (tick) begin
                prescaler <= '0;
                count_val <= wrap ? '0 : count_val + 16'd1;
            end else begin
                prescaler <= prescaler + 8'd1;
            end
            unique case (state)
                IDLE: begin
                    if (do_start) begin
                        state  <= RUN;
                        pwm_en <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (shot_done) begin
                        state  <= IDLE;
                        pwm_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (drain_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (start && !stop) begin
                        state <= RUN;
                    end else if (wrap) begin
                        state  <= IDLE;
                        pwm_en <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    pwm_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_ctrl_seq.sv
// tb_pwm_ctrl_seq: table vectors, corner sequences and a randomized
// run against a cycle-level model of the PWM controller.
`timescale 1ns/1ps
module tb_pwm_ctrl_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        pwm_en;
    logic        period_end;
    logic        busy;
    logic [15:0] period;
    logic [15:0] compare1;
    logic [15:0] compare2;
    logic [15:0] count_val;
    logic [1:0]  functions;

    pwm_ctrl_seq_if cfg();

    pwm_ctrl_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg        (cfg),
        .start      (start),
        .stop       (stop),
        .pwm_en     (pwm_en),
        .period     (period),
        .functions  (functions),
        .compare1   (compare1),
        .compare2   (compare2),
        .count_val  (count_val),
        .period_end (period_end),
        .busy       (busy)
    );

    always #5 clk = ~clk;

`ifdef PWM_CTRL_ONESHOT_EN
    localparam int NADDR = 6;
`else
    localparam int NADDR = 5;
`endif

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] a,
                         input logic [15:0] d, input logic st,
                         input logic sp);
        cfg.cfg_valid = v;
        cfg.cfg_addr  = a;
        cfg.cfg_wdata = d;
        start = st;
        stop  = sp;
        @(posedge clk);
        #1;
        cfg.cfg_valid = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cfg.cfg_valid = 1'b0;
        cfg.cfg_addr  = 3'd0;
        cfg.cfg_wdata = 16'd0;
        start = 1'b0;
        stop  = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Wait (bounded) until pwm_en drops; n returns cycles used or -1
    task automatic wait_en_low(input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            idle_cycle();
            if (!pwm_en) begin
                n = k;
                break;
            end
        end
    endtask

    // Behavioural model: register banks as arrays, mode 0/1/2 =
    // stopped / running / finishing the current period.
    int m_sh[6];
    int m_act[6];
    bit m_dirty;
    bit m_pe;
    bit m_rdy;
    int m_mode;
    int m_pre;
    int m_cnt;

    function void m_reset();
        for (int i = 0; i < 6; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
        m_dirty = 0;
        m_pe    = 0;
        m_rdy   = 1;
        m_mode  = 0;
        m_pre   = 0;
        m_cnt   = 0;
    endfunction

    function void m_step(input bit v, input int a, input int d,
                         input bit st, input bit sp);
        int  peff;
        int  msk;
        bit  tick;
        bit  wrap;
        bit  go;
        bit  shot;
        bit  commit;
        shot = (m_act[5] != 0);
        peff = (m_act[0] == 0) ? 1 : m_act[0];
        tick = (m_mode != 0) && (m_pre == m_act[4]);
        wrap = tick && (m_cnt + 1 >= peff);
        go   = (m_mode == 0) && st && !sp;
        if (v && m_rdy && a < NADDR) begin
            msk = (a == 3) ? 3 : (a == 4) ? 255 : (a == 5) ? 1 : 65535;
            m_sh[a] = d & msk;
            m_dirty = 1;
        end
        commit = go || (wrap && m_dirty);
        m_pe = wrap;
        if (m_mode == 0) begin
            m_cnt = 0;
            m_pre = 0;
        end else if (tick) begin
            m_pre = 0;
            m_cnt = wrap ? 0 : m_cnt + 1;
        end else begin
            m_pre = m_pre + 1;
        end
        case (m_mode)
            0: if (go) m_mode = 1;
            1: begin
                if (shot && wrap) m_mode = 0;
                else if (sp || shot) m_mode = 2;
            end
            default: begin
                if (st && !sp) m_mode = 1;
                else if (wrap) m_mode = 0;
            end
        endcase
        if (commit) begin
            for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
            m_dirty = 0;
        end
        m_rdy = !commit;
    endfunction

    typedef struct {
        logic        v;
        logic [2:0]  a;
        logic [15:0] d;
        logic        st;
        logic        sp;
        logic        en;
        logic [15:0] cnt;
        logic        pe;
        logic        rdy;
        logic [15:0] c1;
    } vec_t;

    vec_t tbl [0:16];

    initial begin
        int n;
        int m;
        int pes;
        bit v;
        bit st;
        bit sp;
        int a;
        int d;

        tbl = '{
            '{1'b1, 3'd0, 16'd4, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd0},
            '{1'b1, 3'd1, 16'd2, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd0},
            '{1'b1, 3'd4, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd0},
            '{1'b0, 3'd0, 16'd0, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 16'd2},
            '{1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 16'd2},
            '{1'b1, 3'd1, 16'd3, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b1, 16'd2},
            '{1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd3, 1'b0, 1'b1, 16'd2},
            '{1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0, 16'd3},
            '{1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 16'd3},
            '{1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b1, 16'd3},
            '{1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd3, 1'b0, 1'b1, 16'd3},
            '{1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b1, 16'd3},
            '{1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 16'd3},
            '{1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0, 1'b1, 16'd3},
            '{1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd3, 1'b0, 1'b1, 16'd3},
            '{1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd3},
            '{1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd3}
        };

        do_reset();
        check("reset_state",
              64'({pwm_en, busy, period_end, cfg.cfg_ready, count_val,
                   period, compare1}),
              64'({1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 16'd0}));

        // Basic run, mid-period write, stop/drain
        for (int i = 0; i <= 16; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].st, tbl[i].sp);
            check($sformatf("vec%0d", i),
                  64'({pwm_en, busy, period_end, cfg.cfg_ready,
                       count_val, compare1}),
                  64'({tbl[i].en, tbl[i].en, tbl[i].pe, tbl[i].rdy,
                       tbl[i].cnt, tbl[i].c1}));
        end

        // prescale 2, period 3: count steps every 3rd cycle, wrap every 9
        drive(1'b1, 3'd0, 16'd3, 1'b0, 1'b0);
        drive(1'b1, 3'd4, 16'd2, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            idle_cycle();
            if (period_end) begin
                n = k;
                break;
            end
        end
        check("presc_first_wrap_seen", 64'(n > 0), 64'(1));
        m = -1;
        for (int k = 1; k <= 20; k++) begin
            idle_cycle();
            if (k == 3) check("presc_cnt_k3", 64'(count_val), 64'(1));
            if (k == 6) check("presc_cnt_k6", 64'(count_val), 64'(2));
            if (period_end) begin
                m = k;
                break;
            end
        end
        check("presc_wrap_interval", 64'(m), 64'(9));
        drive(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
        wait_en_low(40, n);
        check("presc_drain_done", 64'(n > 0), 64'(1));

        // start and stop together while running: stop wins
        drive(1'b1, 3'd0, 16'd4, 1'b0, 1'b0);
        drive(1'b1, 3'd4, 16'd0, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        idle_cycle();
        drive(1'b0, 3'd0, 16'd0, 1'b1, 1'b1);
        check("startstop_still_busy", 64'({pwm_en, busy}), 64'(2'b11));
        wait_en_low(10, n);
        check("startstop_drained", 64'(n > 0), 64'(1));
        check("startstop_end_state",
              64'({busy, period_end, count_val}),
              64'({1'b0, 1'b1, 16'd0}));

        // period 0 acts as period 1
        drive(1'b1, 3'd0, 16'd0, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            idle_cycle();
            check($sformatf("per0_k%0d", k),
                  64'({pwm_en, period_end, count_val}),
                  64'({1'b1, 1'b1, 16'd0}));
        end

        // asynchronous reset mid-run, shadows discarded
        drive(1'b1, 3'd1, 16'd9, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset",
              64'({pwm_en, busy, period_end, cfg.cfg_ready, count_val,
                   period, compare1}),
              64'({1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 16'd0}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        check("reset_discards_shadow",
              64'({compare1, period, pwm_en}),
              64'({16'd0, 16'd0, 1'b1}));

`ifdef PWM_CTRL_ONESHOT_EN
        do_reset();
        drive(1'b1, 3'd5, 16'd1, 1'b0, 1'b0);
        drive(1'b1, 3'd0, 16'd5, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
        pes = 0;
        for (int k = 0; k < 30; k++) begin
            idle_cycle();
            if (period_end) pes++;
        end
        check("oneshot_one_period", 64'(pes), 64'(1));
        check("oneshot_idle", 64'({pwm_en, busy}), 64'(0));
`endif

        // randomized traffic against the model
        do_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            v  = ($urandom_range(0, 2) == 0);
            a  = $urandom_range(0, 7);
            d  = int'($urandom & 32'hffff);
            if (a == 0) d = $urandom_range(0, 6);
            if (a == 4) d = (d & 16'hff00) | $urandom_range(0, 2);
            st = ($urandom_range(0, 14) == 0);
            sp = ($urandom_range(0, 24) == 0);
            drive(v, 3'(a), 16'(d), st, sp);
            m_step(v, a, d, st, sp);
            check("rand_ctl",
                  64'({pwm_en, busy, period_end, cfg.cfg_ready,
                       count_val}),
                  64'({m_mode != 0, m_mode != 0, m_pe, m_rdy,
                       16'(m_cnt)}));
            check("rand_cfg",
                  64'({period, compare1, compare2, functions}),
                  64'({16'(m_act[0]), 16'(m_act[1]), 16'(m_act[2]),
                       2'(m_act[3])}));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
